// File: rtl/dma_chan_sched_pkg.sv
// Shared types for the DMA channel scheduler slice.
package dma_chan_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FIN    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      pos_idx = IDX_W'(pos);
      if (!valid && req[pos_idx]) begin
        valid          = 1'b1;
        idx            = pos_idx;
        grant[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin multi-channel job scheduler driving a single DMA engine,
// with launch/run/finish sequencing and a launch-to-done watchdog.
module dma_chan_sched
  import dma_chan_sched_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SIZE_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_src,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_dst,
  input  logic [NUM_CH*SIZE_W-1:0]   ch_size,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_err,
  output logic                       sched_busy,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       dma_start,
  output logic [ADDR_W-1:0]          dma_src,
  output logic [ADDR_W-1:0]          dma_dst,
  output logic [SIZE_W-1:0]          dma_size,
  input  logic                       dma_busy,
  input  logic                       dma_done
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, arb_idx, active_nxt;
  logic [NUM_CH-1:0] arb_grant;
  logic              arb_valid;
  logic [WD_W-1:0]   wd_q;
  logic              take, timeout_hit;
  logic [ADDR_W-1:0] sel_src, sel_dst;
  logic [SIZE_W-1:0] sel_size;
  logic [NUM_CH-1:0] grant_d, done_d, err_d;
  logic              start_d, busy_d;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_src  = ch_src [32'(arb_idx) * ADDR_W +: ADDR_W];
  assign sel_dst  = ch_dst [32'(arb_idx) * ADDR_W +: ADDR_W];
  assign sel_size = ch_size[32'(arb_idx) * SIZE_W +: SIZE_W];

  assign take        = (state_q == ST_IDLE) && arb_valid && !dma_busy;
  // A done pulse in the final watchdog cycle takes priority over the timeout.
  assign timeout_hit = (state_q == ST_RUN) && !dma_done && (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);
  assign active_nxt  = take ? arb_idx : active_ch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (take) state_d = (sel_size != '0) ? ST_LAUNCH : ST_FIN;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (dma_done || timeout_hit) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so every
  // pulse appears in the same cycle as the state it belongs to.
  always_comb begin
    grant_d = take ? arb_grant : '0;
    done_d  = (state_d == ST_FIN) ? (NUM_CH'(1) << active_nxt) : '0;
    err_d   = timeout_hit ? done_d : '0;
    start_d = (state_d == ST_LAUNCH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_grant   <= '0;
      ch_done    <= '0;
      ch_err     <= '0;
      dma_start  <= 1'b0;
      sched_busy <= 1'b0;
      active_ch  <= '0;
      dma_src    <= '0;
      dma_dst    <= '0;
      dma_size   <= '0;
      rr_ptr_q   <= '0;
      wd_q       <= '0;
    end else begin
      ch_grant   <= grant_d;
      ch_done    <= done_d;
      ch_err     <= err_d;
      dma_start  <= start_d;
      sched_busy <= busy_d;
      if (take) begin
        dma_src   <= sel_src;
        dma_dst   <= sel_dst;
        dma_size  <= sel_size;
        active_ch <= arb_idx;
        rr_ptr_q  <= (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + IDX_W'(1);
      end
      if (state_q == ST_LAUNCH)   wd_q <= '0;
      else if (state_q == ST_RUN) wd_q <= wd_q + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed scenarios plus random traffic checked against a job-timeline model.
module tb_dma_chan_sched;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int SIZE_W = 32;
  localparam int TMO    = 16;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_CH-1:0]         ch_req = '0;
  logic [NUM_CH*ADDR_W-1:0]  ch_src = '0;
  logic [NUM_CH*ADDR_W-1:0]  ch_dst = '0;
  logic [NUM_CH*SIZE_W-1:0]  ch_size = '0;
  logic [NUM_CH-1:0]         ch_grant, ch_done, ch_err;
  logic                      sched_busy;
  logic [1:0]                active_ch;
  logic                      dma_start;
  logic [ADDR_W-1:0]         dma_src, dma_dst;
  logic [SIZE_W-1:0]         dma_size;
  logic                      dma_busy = 1'b0;
  logic                      dma_done = 1'b0;

  always #5 clk = ~clk;

  dma_chan_sched #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .SIZE_W      (SIZE_W),
    .TIMEOUT_CYC (TMO)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_req     (ch_req),
    .ch_src     (ch_src),
    .ch_dst     (ch_dst),
    .ch_size    (ch_size),
    .ch_grant   (ch_grant),
    .ch_done    (ch_done),
    .ch_err     (ch_err),
    .sched_busy (sched_busy),
    .active_ch  (active_ch),
    .dma_start  (dma_start),
    .dma_src    (dma_src),
    .dma_dst    (dma_dst),
    .dma_size   (dma_size),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle events, keyed by cycle number.
  logic [NUM_CH-1:0] eg [int];
  logic [NUM_CH-1:0] ed [int];
  logic [NUM_CH-1:0] ee [int];
  bit                es [int];
  logic [31:0]       ex_src [int];
  logic [31:0]       ex_dst [int];
  logic [31:0]       ex_size [int];

  int m_ptr = 0, m_active = 0, next_free_edge = 0;
  int done_edge = -1, busy_from = 0, sb_from = 1, sb_to = 0;
  int force_lat = 0;
  bit rand_en = 0;

  bit          pend [NUM_CH];
  bit          granted [NUM_CH];
  logic [31:0] j_src [NUM_CH];
  logic [31:0] j_dst [NUM_CH];
  logic [31:0] j_size [NUM_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic post(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] sz);
    pend[ch]   = 1'b1;
    j_src[ch]  = s;
    j_dst[ch]  = d;
    j_size[ch] = sz;
  endtask

  // Model: a job decided at edge c+1 occupies cycles c+1..f; the engine
  // answers L cycles after the decision edge, the watchdog allows TMO run cycles.
  task automatic schedule(input int c, input logic [NUM_CH-1:0] rq);
    int w, lat, p, lim, f;
    bit err;
    logic [NUM_CH-1:0] oh;
    w = -1;
    err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int ch;
      ch = (m_ptr + i) % NUM_CH;
      if (w < 0 && rq[ch]) w = ch;
    end
    m_ptr = (w + 1) % NUM_CH;
    m_active = w;
    granted[w] = 1'b1;
    oh = '0;
    oh[w] = 1'b1;
    eg[c+1] = oh;
    ex_src[c+1] = j_src[w];
    ex_dst[c+1] = j_dst[w];
    ex_size[c+1] = j_size[w];
    if (j_size[w] == 0) begin
      f = c + 1;
    end else begin
      es[c+1] = 1'b1;
      if (force_lat != 0) lat = force_lat;
      else lat = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : $urandom_range(2, 22);
      p = c + 1 + lat;
      lim = c + 2 + TMO;
      if (p <= lim) f = p;
      else begin
        f = lim;
        err = 1'b1;
      end
      done_edge = p;
      busy_from = c + 2;
    end
    ed[f] = oh;
    if (err) ee[f] = oh;
    sb_from = c + 1;
    sb_to = f;
    next_free_edge = f + 2;
  endtask

  task automatic step();
    int c;
    logic [NUM_CH-1:0] rq;
    @(negedge clk);
    c = cyc;
    check("grant", ch_grant, eg.exists(c) ? eg[c] : '0);
    check("done", ch_done, ed.exists(c) ? ed[c] : '0);
    check("err", ch_err, ee.exists(c) ? ee[c] : '0);
    check("start", dma_start, 64'(es.exists(c)));
    check("busy", sched_busy, 64'(c >= sb_from && c <= sb_to));
    check("active", active_ch, m_active);
    if (ex_src.exists(c)) begin
      check("src", dma_src, ex_src[c]);
      check("dst", dma_dst, ex_dst[c]);
      check("size", dma_size, ex_size[c]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (granted[i]) begin
        pend[i] = 1'b0;
        granted[i] = 1'b0;
      end else if (rand_en && reset_n) begin
        if (!pend[i] && $urandom_range(0, 7) == 0)
          post(i, $urandom, $urandom, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 64));
        else if (pend[i] && $urandom_range(0, 63) == 0)
          pend[i] = 1'b0;
      end
    end
    dma_done = (c + 1 == done_edge);
    dma_busy = (c + 1 >= busy_from) && (c + 1 < done_edge);
    for (int i = 0; i < NUM_CH; i++) begin
      rq[i] = pend[i];
      ch_src[i*ADDR_W +: ADDR_W]  = j_src[i];
      ch_dst[i*ADDR_W +: ADDR_W]  = j_dst[i];
      ch_size[i*SIZE_W +: SIZE_W] = j_size[i];
    end
    ch_req = rq;
    if (reset_n && c + 1 >= next_free_edge && rq != '0 && !dma_busy) schedule(c, rq);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    eg.delete(); ed.delete(); ee.delete(); es.delete();
    ex_src.delete(); ex_dst.delete(); ex_size.delete();
    m_ptr = 0; m_active = 0;
    done_edge = -1; busy_from = 0; sb_from = 1; sb_to = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i] = 1'b0;
      granted[i] = 1'b0;
    end
    ch_req = '0; dma_done = 1'b0; dma_busy = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    next_free_edge = cyc + 1;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i] = 1'b0; granted[i] = 1'b0;
      j_src[i] = '0; j_dst[i] = '0; j_size[i] = '0;
    end
    do_reset();

    // single job on ch0
    force_lat = 6;
    post(0, 32'h1000, 32'h2000, 32'd8);
    repeat (20) step();

    // reset while the job is running
    force_lat = 12;
    post(0, 32'h3000, 32'h4000, 32'd16);
    repeat (5) step();
    do_reset();

    // all four at once from pointer 0, then ch1 and ch3 again
    force_lat = 3;
    for (int i = 0; i < NUM_CH; i++) post(i, 32'h100 * i, 32'h8000 + i, 32'd4);
    repeat (40) step();
    post(1, 32'hA1, 32'hB1, 32'd4);
    post(3, 32'hA3, 32'hB3, 32'd4);
    repeat (30) step();

    // zero-size job: grant and done together, no engine launch
    post(2, 32'hC0C0, 32'hD0D0, 32'd0);
    repeat (6) step();

    // watchdog expiry, late done ignored, next job waits for engine idle
    force_lat = 20;
    post(0, 32'h5000, 32'h6000, 32'd8);
    repeat (3) step();
    force_lat = 4;
    post(1, 32'h5100, 32'h6100, 32'd4);
    repeat (45) step();

    // ch1 withdraws just before its turn; ch2 is served instead
    force_lat = 10;
    post(3, 32'h7000, 32'h7100, 32'd8);
    repeat (3) step();
    post(1, 32'h7200, 32'h7300, 32'd2);
    post(2, 32'h7400, 32'h7500, 32'd2);
    repeat (5) step();
    pend[1] = 1'b0;
    repeat (30) step();

    force_lat = 0;
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
